// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the elastic pipeline register: FSM state encoding,
// default widths and the state-to-occupancy decode.
package pipe_pkg;

   localparam int DEFAULT_WIDTH = 144;
   localparam int DEFAULT_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   // Number of words held in each state; the unused encoding reports zero.
   function automatic logic [1:0] stateOccupancy(input pipe_state_e state);
      logic [1:0] occ;
      occ = 2'd0;
      case (state)
         ST_EMPTY: occ = 2'd0;
         ST_BUSY:  occ = 2'd1;
         ST_FULL:  occ = 2'd2;
         default:  occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle: upstream write side and downstream read side.
// The register itself uses the slave view; whatever drives it uses master.
interface pipe_skid_reg_if #(
   parameter int WIDTH = pipe_pkg::DEFAULT_WIDTH
);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with load enable and synchronous active-low reset
// to zero; used for both the main and the skid word.
module pipe_data_reg #(
   parameter int WIDTH = pipe_pkg::DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = d_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid) with full throughput and
// no combinational path from out_ready to in_ready.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   pipe_skid_reg_if.slave   bus,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] xfer_count
);

   pipe_state_e      state_q;
   pipe_state_e      state_d;
   logic             inReady;
   logic             outValid;
   logic             inFire;
   logic             outFire;
   logic             mainLoad;
   logic             mainFromSkid;
   logic             skidLoad;
   logic [WIDTH-1:0] mainNext;
   logic [WIDTH-1:0] mainData_q;
   logic [WIDTH-1:0] skidData_q;
   logic [CNT_W-1:0] xferCount_q;
   logic [CNT_W-1:0] xferCount_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Handshake outputs come from the state register alone, so neither ready
   // nor valid ever sees a combinational input.
   always_comb begin
      inReady  = 1'b1;
      outValid = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            inReady  = 1'b1;
            outValid = 1'b0;
         end
         ST_BUSY: begin
            inReady  = 1'b1;
            outValid = 1'b1;
         end
         ST_FULL: begin
            inReady  = 1'b0;
            outValid = 1'b1;
         end
         default: begin
            inReady  = 1'b1;
            outValid = 1'b0;
         end
      endcase
   end

   assign inFire  = bus.in_valid & inReady;
   assign outFire = outValid & bus.out_ready;

   always_comb begin
      state_d      = state_q;
      mainLoad     = 1'b0;
      mainFromSkid = 1'b0;
      skidLoad     = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (inFire) begin
               mainLoad = 1'b1;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (inFire && !outFire) begin
               skidLoad = 1'b1;
               state_d  = ST_FULL;
            end else if (inFire && outFire) begin
               mainLoad = 1'b1;
            end else if (outFire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (outFire) begin
               mainLoad     = 1'b1;
               mainFromSkid = 1'b1;
               state_d      = ST_BUSY;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      // Flush empties the stage; data registers are left stale since out_valid
      // drops with the state.
      if (flush) begin
         state_d  = ST_EMPTY;
         mainLoad = 1'b0;
         skidLoad = 1'b0;
      end
   end

   assign mainNext = mainFromSkid ? skidData_q : bus.in_data;

   pipe_data_reg #(
      .WIDTH (WIDTH)
   ) mainReg (
      .clk    (clk),
      .reset  (reset),
      .load_i (mainLoad),
      .d_i    (mainNext),
      .q_o    (mainData_q)
   );

   pipe_data_reg #(
      .WIDTH (WIDTH)
   ) skidReg (
      .clk    (clk),
      .reset  (reset),
      .load_i (skidLoad),
      .d_i    (bus.in_data),
      .q_o    (skidData_q)
   );

   // Transfer counter survives flush: a word consumed alongside a flush was
   // still delivered downstream.
   always_comb begin
      xferCount_d = xferCount_q;
      if (outFire) begin
         xferCount_d = xferCount_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         xferCount_q <= '0;
      end else begin
         xferCount_q <= xferCount_d;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid;
   assign bus.out_data  = mainData_q;
   assign occupancy     = stateOccupancy(state_q);
   assign xfer_count    = xferCount_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a negedge scoreboard tracks accepted words
// and the transfer count, while the main sequence checks timing at each step.
module tb_pipe_skid_reg;

   localparam int W      = 144;
   localparam int TB_CNT = 4;

   typedef logic [W-1:0] word_t;

   logic              clk;
   logic              reset;
   logic              flush;
   logic [1:0]        occupancy;
   logic [TB_CNT-1:0] xfer_count;
   logic [TB_CNT-1:0] expCount;
   logic              monitorOn;
   int                evaluated;
   int                failures;
   word_t             expQ[$];
   word_t             expWord;

   pipe_skid_reg_if #(.WIDTH(W)) bus ();

   pipe_skid_reg #(
      .WIDTH (W),
      .CNT_W (TB_CNT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .bus        (bus.slave),
      .occupancy  (occupancy),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
      evaluated++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs just after a rising edge and let it be sampled.
   task automatic applyStimulus(input logic valid, input word_t data, input logic outReady,
                                input logic doFlush);
      bus.in_valid  = valid;
      bus.in_data   = data;
      bus.out_ready = outReady;
      flush         = doFlush;
      @(posedge clk);
      #1;
   endtask

   task automatic checkState(input string tag, input logic inRdy, input logic outVld,
                             input logic [1:0] occ);
      checkOutput({tag, "_in_ready"}, word_t'(bus.in_ready), word_t'(inRdy));
      checkOutput({tag, "_out_valid"}, word_t'(bus.out_valid), word_t'(outVld));
      checkOutput({tag, "_occupancy"}, word_t'(occupancy), word_t'(occ));
   endtask

   // Scoreboard: sampled mid-cycle, between the input drive and the edge.
   always @(negedge clk) begin
      if (monitorOn) begin
         checkOutput("sb_xfer_count", word_t'(xfer_count), word_t'(expCount));
         if (!reset) begin
            expQ.delete();
            expCount = '0;
         end else begin
            if (bus.out_valid && bus.out_ready) begin
               checkOutput("sb_word_pending", word_t'(expQ.size() > 0), word_t'(1));
               if (expQ.size() > 0) begin
                  expWord = expQ.pop_front();
                  checkOutput("sb_out_data", bus.out_data, expWord);
               end
               expCount = expCount + TB_CNT'(1);
            end
            if (flush) begin
               expQ.delete();
            end else if (bus.in_valid && bus.in_ready) begin
               expQ.push_back(bus.in_data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      evaluated     = 0;
      failures      = 0;
      monitorOn     = 1'b0;
      expCount      = '0;
      reset         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset values");
      checkState("rst", 1'b1, 1'b0, 2'd0);
      checkOutput("rst_out_data", bus.out_data, '0);
      checkOutput("rst_skid", dut.skidData_q, '0);
      checkOutput("rst_xfer_count", word_t'(xfer_count), '0);
      monitorOn = 1'b1;
      reset     = 1'b1;

      $display("[TB] streaming 0x01..0x08");
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, word_t'(i), 1'b1, 1'b0);
         checkState("stream", 1'b1, 1'b1, 2'd1);
         checkOutput("stream_latency", bus.out_data, word_t'(i));
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkState("stream_drain", 1'b1, 1'b0, 2'd0);
      checkOutput("stream_count", word_t'(xfer_count), word_t'(8));

      $display("[TB] single stall");
      applyStimulus(1'b1, word_t'('hA0), 1'b1, 1'b0);
      applyStimulus(1'b1, word_t'('hA1), 1'b1, 1'b0);
      checkOutput("stall_a1", bus.out_data, word_t'('hA1));
      applyStimulus(1'b1, word_t'('hA2), 1'b0, 1'b0);
      checkState("stall_full", 1'b0, 1'b1, 2'd2);
      checkOutput("stall_hold_a1", bus.out_data, word_t'('hA1));
      applyStimulus(1'b1, word_t'('hA3), 1'b1, 1'b0);
      checkState("stall_recover", 1'b1, 1'b1, 2'd1);
      checkOutput("stall_a2", bus.out_data, word_t'('hA2));
      applyStimulus(1'b1, word_t'('hA3), 1'b1, 1'b0);
      checkOutput("stall_a3", bus.out_data, word_t'('hA3));
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("stall_count", word_t'(xfer_count), word_t'(12));

      $display("[TB] full hold");
      applyStimulus(1'b1, word_t'('h11), 1'b0, 1'b0);
      applyStimulus(1'b1, word_t'('h22), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, word_t'('h33), 1'b0, 1'b0);
         checkState("hold", 1'b0, 1'b1, 2'd2);
         checkOutput("hold_out", bus.out_data, word_t'('h11));
      end
      applyStimulus(1'b1, word_t'('h33), 1'b1, 1'b0);
      checkState("hold_release", 1'b1, 1'b1, 2'd1);
      checkOutput("hold_22", bus.out_data, word_t'('h22));
      applyStimulus(1'b1, word_t'('h33), 1'b1, 1'b0);
      checkOutput("hold_33", bus.out_data, word_t'('h33));
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("hold_count", word_t'(xfer_count), word_t'(15));

      $display("[TB] flush in FULL with coincident out_fire");
      applyStimulus(1'b1, word_t'('h66), 1'b0, 1'b0);
      applyStimulus(1'b1, word_t'('h77), 1'b0, 1'b0);
      checkState("pre_flush", 1'b0, 1'b1, 2'd2);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkState("flush", 1'b1, 1'b0, 2'd0);
      checkOutput("flush_count_wrap", word_t'(xfer_count), word_t'(0));
      applyStimulus(1'b1, word_t'('h55), 1'b1, 1'b0);
      checkState("post_flush", 1'b1, 1'b1, 2'd1);
      checkOutput("post_flush_55", bus.out_data, word_t'('h55));
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("post_flush_count", word_t'(xfer_count), word_t'(1));

      $display("[TB] flush discards coincident in_fire");
      applyStimulus(1'b1, word_t'('h88), 1'b0, 1'b0);
      applyStimulus(1'b1, word_t'('h99), 1'b0, 1'b1);
      checkState("flush_busy", 1'b1, 1'b0, 2'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkState("flush_busy_idle", 1'b1, 1'b0, 2'd0);
      checkOutput("flush_busy_count", word_t'(xfer_count), word_t'(1));

      $display("[TB] counter wrap");
      reset = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      reset = 1'b1;
      checkOutput("wrap_start", word_t'(xfer_count), '0);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, word_t'(i + 'h100), 1'b1, 1'b0);
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("wrap_count", word_t'(xfer_count), word_t'(1));

      $display("[TB] reset in FULL");
      applyStimulus(1'b1, word_t'('hC1), 1'b0, 1'b0);
      applyStimulus(1'b1, word_t'('hC2), 1'b0, 1'b0);
      checkState("pre_reset", 1'b0, 1'b1, 2'd2);
      reset = 1'b0;
      applyStimulus(1'b1, word_t'('hC3), 1'b1, 1'b0);
      reset = 1'b1;
      checkState("mid_reset", 1'b1, 1'b0, 2'd0);
      checkOutput("mid_reset_out_data", bus.out_data, '0);
      checkOutput("mid_reset_skid", dut.skidData_q, '0);
      checkOutput("mid_reset_count", word_t'(xfer_count), '0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         checkOutput("no_stale_word", word_t'(bus.out_valid), '0);
      end
      checkOutput("sb_drained", word_t'(expQ.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Elastic pipeline register with a valid/ready handshake on both sides. It is the backpressure-aware counterpart to the free-running D-flip-flop stages: the upstream side writes one word per cycle when `in_ready` is high, and the downstream side reads when it asserts `out_ready`. It sits between the 144-bit window/weight stages and consumers that can stall, such as the PE array input or the output accumulator. A two-entry main/skid storage gives full throughput with no combinational path from `out_ready` to `in_ready`.

## Interface
- `WIDTH`, default 144: data word width in bits.
- `CNT_W`, default 16: width of the transfer counter.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `flush` input 1: synchronous discard of all held words. Active high.
- `in_data` input WIDTH: upstream word.
- `in_valid` input 1: upstream word present.
- `in_ready` output 1: block can accept a word this cycle. Registered.
- `out_data` output WIDTH: word presented downstream. Driven from the main register.
- `out_valid` output 1: `out_data` is valid. Registered.
- `out_ready` input 1: downstream accepts `out_data` this cycle.
- `occupancy` output 2: words held, 0 to 2.
- `xfer_count` output CNT_W: count of downstream transfers.

## Operation
- Fire events:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
- FSM states and outputs:
  - EMPTY: occupancy 0, `in_ready` 1, `out_valid` 0.
  - BUSY: occupancy 1, `in_ready` 1, `out_valid` 1.
  - FULL: occupancy 2, `in_ready` 0, `out_valid` 1.
- EMPTY transitions:
  - `in_fire`: main <= `in_data`, go to BUSY.
  - Otherwise stay in EMPTY.
- BUSY transitions:
  - `in_fire` and not `out_fire`: skid <= `in_data`, go to FULL.
  - `in_fire` and `out_fire`: main <= `in_data`, stay in BUSY.
  - `out_fire` only: go to EMPTY.
  - Neither: hold.
- FULL transitions:
  - `out_fire`: main <= skid, go to BUSY.
  - Otherwise hold.
  - `in_fire` is impossible in FULL because `in_ready` is 0.
- `in_valid` while `in_ready` is 0: ignored, and the word is not captured. Upstream must hold its word; this is not checked.
- Ordering: strict FIFO. Words leave in acceptance order with no duplication or loss, except on flush.
- `xfer_count`: increments by 1 on each `out_fire` and wraps modulo 2^CNT_W. Flush does not clear it; reset does.
- `flush`:
  - Next state is EMPTY regardless of the fire events.
  - A coincident `in_fire` is discarded.
  - A coincident `out_fire` still counts, because downstream consumed the word.
  - Data registers keep stale contents; `out_valid` is 0, so they are don't-care.
- Priority order: `reset`, then `flush`, then handshake.

## Timing
- Reset values, on a clock edge with `reset` = 0:
  - State EMPTY, `in_ready` 1, `out_valid` 0, `occupancy` 0.
  - `out_data` 0, skid register 0, `xfer_count` 0.
- Reset asserted mid-operation drops all held words at the next edge; no partial state survives.
- Latency: a word accepted at edge N is on `out_data` with `out_valid` = 1 after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle sustained while `out_ready` stays at 1, with `occupancy` steady at 1.
- Stall response: `out_ready` low for one cycle with input streaming fills the skid register. `in_ready` falls 1 cycle later, after entering FULL.
- `in_ready`, `out_valid` and `occupancy` decode from registered state only. No input-to-output combinational path exists except `out_data` from the main register.

## Structure
- Shared package `pipe_pkg`:
  - State encoding: ST_EMPTY = 2'd0, ST_BUSY = 2'd1, ST_FULL = 2'd2.
  - Default WIDTH 144.
- Sub-module `pipe_data_reg`:
  - Parameterized WIDTH register with load enable and synchronous active-low reset to 0.
  - Instantiated twice, as main and skid.
- The top module holds the FSM, the enable/mux logic (main loads from `in_data` or from skid) and the counter.

## Test plan
- Reset then stream: hold `out_ready` = 1 and send 0x01..0x08 on consecutive cycles. Expect each word one cycle later in order, `in_ready` always 1, `occupancy` 1, `xfer_count` = 8.
- Single stall: streaming 0xA0..0xA3, drop `out_ready` for the cycle presenting 0xA1.
  - Expect `occupancy` 2 and `in_ready` 0 the next cycle.
  - Expect output order 0xA0, 0xA1, 0xA2, 0xA3 with none lost.
- Full hold: fill with 0x11 and 0x22 and hold `out_ready` = 0 for 5 cycles while `in_valid` = 1 with 0x33.
  - Expect 0x33 not captured until `in_ready` returns.
  - Expect output 0x11, 0x22, then 0x33.
- Flush in FULL with a coincident `out_fire`: expect `occupancy` 0, `out_valid` 0 next cycle and `xfer_count` incremented by 1. A new word 0x55 afterwards emerges with 1-cycle latency.
- Counter wrap with CNT_W = 4: 17 transfers give `xfer_count` = 1.
- Reset mid-operation in FULL: expect all reset values next cycle and no stale word emitted.
